// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-cell up/down counter: the J/K command encoding
// and the terminal count values of a modulo-N range.
package jk_updown_counter_pkg;

  // The command is the {J, K} pair applied to one JK cell.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  localparam logic [1:0] JK_CMD_HOLD   = JK_HOLD;
  localparam logic [1:0] JK_CMD_RESET  = JK_RESET;
  localparam logic [1:0] JK_CMD_SET    = JK_SET;
  localparam logic [1:0] JK_CMD_TOGGLE = JK_TOGGLE;

  // Counting up ends at modulus-1; counting down ends at 0.
  function automatic int terminal_value(input logic dir_up, input int modulus);
    return dir_up ? (modulus - 1) : 0;
  endfunction

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// One JK flip-flop with synchronous active-high reset; the storage element of
// each counter bit.
module jk_cell
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  // NOTE: state registers use non-blocking assignments so every cell samples
  // its neighbours' pre-edge values, just like real flip-flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      unique case (jk_cmd_e'({i_j, i_k}))
        JK_HOLD:   r_q <= r_q;
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter built from JK cells, with parallel
// load, terminal-count flag and registered wrap / load-error pulses.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  import jk_updown_counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(terminal_value(1'b1, MODULUS));
  localparam logic [WIDTH-1:0] MIN_Q   = WIDTH'(terminal_value(1'b0, MODULUS));
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_wrap_d;
  logic             w_err_d;
  logic             r_wrap;
  logic             r_load_err;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next   = w_q;
    w_j      = '0;
    w_k      = '0;
    w_wrap_d = 1'b0;
    w_err_d  = 1'b0;
    if (load) begin
      if ({1'b0, din} < MOD_EXT) begin
        w_next = din;
      end else begin
        w_next  = MIN_Q;
        w_err_d = 1'b1;
      end
      w_j = w_next;
      w_k = ~w_next;
    end else if (en) begin
      // Arithmetic is widened by one bit so q+1 cannot overflow at 2^WIDTH-1.
      if (up) begin
        if (w_q == MAX_Q) begin
          w_next   = MIN_Q;
          w_wrap_d = 1'b1;
        end else begin
          w_next = WIDTH'({1'b0, w_q} + 1'b1);
        end
      end else begin
        if (w_q == MIN_Q) begin
          w_next   = MAX_Q;
          w_wrap_d = 1'b1;
        end else begin
          w_next = WIDTH'({1'b0, w_q} - 1'b1);
        end
      end
      w_j = w_q ^ w_next;
      w_k = w_q ^ w_next;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .i_j   (w_j[gi]),
      .i_k   (w_k[gi]),
      .o_q   (w_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_d;
      r_load_err <= w_err_d;
    end
  end

  assign q        = w_q;
  assign tc       = (up && (w_q == MAX_Q)) || (!up && (w_q == MIN_Q));
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench: a modulo-arithmetic model checked every cycle against a
// decade counter (4 bits, mod 10) and an octal counter (3 bits, mod 8).
module tb_jk_updown_counter;

  localparam int MOD_A = 10;
  localparam int MOD_B = 8;

  typedef struct {
    int q;
    bit wrap;
    bit err;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, up_a, load_a;
  logic [3:0] din_a, q_a;
  logic       tc_a, wrap_a, err_a;

  logic       rst_b, en_b, up_b, load_b;
  logic [2:0] din_b, q_b;
  logic       tc_b, wrap_b, err_b;

  int checks = 0;
  int errors = 0;

  jk_updown_counter #(.WIDTH(4), .MODULUS(MOD_A)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .load(load_a), .din(din_a),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  jk_updown_counter #(.WIDTH(3), .MODULUS(MOD_B)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .load(load_b), .din(din_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mstate_t model_next(input mstate_t s, input bit rst, input bit ld,
                                         input bit en, input bit up, input int din,
                                         input int m);
    mstate_t n;
    n.q    = s.q;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (rst) begin
      n.q = 0;
    end else if (ld) begin
      if (din < m) n.q = din;
      else begin
        n.q   = 0;
        n.err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        n.wrap = (s.q == m - 1);
        n.q    = (s.q + 1) % m;
      end else begin
        n.wrap = (s.q == 0);
        n.q    = (s.q + m - 1) % m;
      end
    end
    return n;
  endfunction

  mstate_t ma, mb;
  bit va = 1'b0, vb = 1'b0;

  always @(posedge clk) begin
    ma = model_next(ma, rst_a, load_a, en_a, up_a, int'(din_a), MOD_A);
    mb = model_next(mb, rst_b, load_b, en_b, up_b, int'(din_b), MOD_B);
    if (rst_a) va = 1'b1;
    if (rst_b) vb = 1'b1;
  end

  always @(negedge clk) begin
    if (va) begin
      check("a_q", int'(q_a), ma.q);
      check("a_tc", int'(tc_a), int'(up_a ? (ma.q == MOD_A - 1) : (ma.q == 0)));
      check("a_wrap", int'(wrap_a), int'(ma.wrap));
      check("a_load_err", int'(err_a), int'(ma.err));
    end
    if (vb) begin
      check("b_q", int'(q_b), mb.q);
      check("b_tc", int'(tc_b), int'(up_b ? (mb.q == MOD_B - 1) : (mb.q == 0)));
      check("b_wrap", int'(wrap_b), int'(mb.wrap));
      check("b_load_err", int'(err_b), int'(mb.err));
    end
  end

  // Wait for one rising edge, then sit just past the following falling edge.
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_a(input bit rst, input bit ld, input bit en, input bit up,
                       input int din);
    rst_a  = rst;
    load_a = ld;
    en_a   = en;
    up_a   = up;
    din_a  = 4'(din);
  endtask

  initial begin
    set_a(1, 0, 0, 1, 0);
    rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; din_b = '0;

    // Reset state
    cycle();
    check("lit_rst_q", int'(q_a), 0);
    check("lit_rst_wrap", int'(wrap_a), 0);
    check("lit_rst_err", int'(err_a), 0);

    // Count up 12 cycles: 1..9, 0, 1, 2
    set_a(0, 0, 1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("lit_up_q", int'(q_a), i % MOD_A);
      check("lit_up_wrap", int'(wrap_a), int'(i == 10));
      check("lit_up_tc", int'(tc_a), int'((i % MOD_A) == 9));
    end

    // Reset mid-count, then count down: 9 (wrap), 8, 7
    set_a(1, 0, 1, 0, 0);
    cycle();
    check("lit_rst2_q", int'(q_a), 0);
    set_a(0, 0, 1, 0, 0);
    #1;
    check("lit_dn_tc0", int'(tc_a), 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("lit_dn_q", int'(q_a), 9 - i);
      check("lit_dn_wrap", int'(wrap_a), int'(i == 0));
    end

    // Load beats enable, then two up-counts
    set_a(0, 1, 1, 1, 5);
    cycle();
    check("lit_ld5_q", int'(q_a), 5);
    check("lit_ld5_err", int'(err_a), 0);
    set_a(0, 0, 1, 1, 0);
    cycle();
    check("lit_ld_up6", int'(q_a), 6);
    cycle();
    check("lit_ld_up7", int'(q_a), 7);

    // Out-of-range load: q=0 with a one-cycle error pulse
    set_a(0, 1, 0, 1, 12);
    cycle();
    check("lit_ld12_q", int'(q_a), 0);
    check("lit_ld12_err", int'(err_a), 1);
    set_a(0, 0, 0, 1, 0);
    cycle();
    check("lit_ld12_err_clr", int'(err_a), 0);

    // Boundary loads: first invalid value, then the largest valid one
    set_a(0, 1, 0, 1, MOD_A);
    cycle();
    check("lit_ld10_err", int'(err_a), 1);
    set_a(0, 1, 0, 1, MOD_A - 1);
    cycle();
    check("lit_ld9_q", int'(q_a), 9);
    check("lit_ld9_err", int'(err_a), 0);
    set_a(0, 0, 1, 1, 0);
    cycle();
    check("lit_ld9_wrap_q", int'(q_a), 0);
    check("lit_ld9_wrap", int'(wrap_a), 1);

    // Reset beats a concurrent load while counting from 6
    set_a(0, 1, 1, 1, 5);
    cycle();
    set_a(0, 0, 1, 1, 0);
    cycle();
    check("lit_pre_rst_q", int'(q_a), 6);
    set_a(1, 1, 1, 1, 3);
    cycle();
    check("lit_rst_ld_q", int'(q_a), 0);
    check("lit_rst_ld_wrap", int'(wrap_a), 0);
    check("lit_rst_ld_err", int'(err_a), 0);
    set_a(0, 0, 1, 1, 0);
    cycle();
    check("lit_resume_q", int'(q_a), 1);
    set_a(0, 0, 0, 1, 0);

    // Power-of-two modulus: natural roll-over from 7, then hold
    rst_b = 1'b0; load_b = 1'b1; din_b = 3'd7;
    cycle();
    check("lit_b_ld7", int'(q_b), 7);
    check("lit_b_tc7", int'(tc_b), 1);
    load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    cycle();
    check("lit_b_roll_q", int'(q_b), 0);
    check("lit_b_roll_wrap", int'(wrap_b), 1);
    en_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("lit_b_hold_q", int'(q_b), 0);
      check("lit_b_hold_wrap", int'(wrap_b), 0);
    end

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
